ifu_fetch_queue: RTL and testbench
==================================

// Module: ifu_fetch_queue
// PURPOSE
//  Parametrised instruction-fetch front end: issues up to MAX_OUTST pipelined fetch requests
//  to IFPCU, buffers in-order responses in a DEPTH-entry circular queue, and presents
//  instructions to IDU with PC, delay-slot flag and branch id. A WBU redirect squashes the
//  queue and drops responses still in flight, with no bubble beyond the redirect cycle.
// PARAMETERS
//  DEPTH       4             instruction queue entries (power of 2, >=2)
//  MAX_OUTST   4             max requests in flight to IFPCU (<=DEPTH)
//  ENTRY       32'hbfc00000  reset fetch PC
//  BID_W       4             branch_id width
// PORTS
//  clk          in   1      clock
//  rst          in   1      reset, synchronous, active-high
//  redir_valid  in   1      WBU redirect (taken branch/exception); always accepted
//  redir_pc     in   32     redirect target (virtual)
//  req_valid    out  1      fetch request to IFPCU
//  req_ready    in   1      IFPCU accepts request
//  req_addr     out  32     physical fetch address
//  resp_valid   in   1      in-order fetch response (always accepted)
//  resp_instr   in   32     fetched instruction word
//  out_valid    out  1      instruction to IDU
//  out_ready    in   1      IDU accepts
//  out_instr    out  32     instruction
//  out_pc       out  32     virtual PC of instruction
//  out_ds       out  1      instruction is in a branch delay slot
//  out_bid      out  BID_W  branch id of owning branch
// BEHAVIOUR
//  Reset: fetch_pc=ENTRY; queue empty; inflight=0; drop_cnt=0; prev_br=0; bid=0;
//   req_valid=0, out_valid=0 in the reset cycle.
//  Address map: req_addr = {3'b000, fetch_pc[28:0]} (kseg0/kseg1 fold); fetch_pc word aligned.
//  Issue: req_valid = !redir_valid & (inflight + count < DEPTH) & (inflight < MAX_OUTST).
//   On req_valid&req_ready: fetch_pc += 4, inflight++ (net with same-cycle resp).
//  Response: resp_valid decrements inflight. If drop_cnt!=0: discard, drop_cnt--.
//   Else enqueue {instr, pc, ds, bid}; pc of entry = enq_pc, then enq_pc += 4.
//   Credit check guarantees no response arrives with queue full; assert on overflow.
//  Predecode at enqueue: branch = op 1,2,3,4-7,20-23, or op 0 with funct 8/9 (JR/JALR).
//   Entry after a branch: ds=1, bid=current bid; a branch entry: bid_next=bid+1 (wraps
//   mod 2^BID_W), entry carries new id; prev_br tracks last enqueued entry.
//  Output: out_* = queue head; out_valid = count!=0; pop on out_valid&out_ready.
//   Queue empty->first entry visible the cycle after enqueue (1-cycle resp->out latency).
//  Redirect (cycle R): queue cleared; fetch_pc=enq_pc=redir_pc; prev_br=0; bid kept;
//   drop_cnt = inflight - (resp_valid in R ? 1 : 0); response in R discarded;
//   no request issued in R; pop in R ignored; out_valid=0 in R+1; first new request in R+1.
//  Simultaneous enqueue+pop: count unchanged; full+pop+enq allowed.
//  Redirect during rst: rst wins. drop_cnt never underflows (inflight bound).
//  Counters inflight/drop_cnt width clog2(MAX_OUTST)+1; count width clog2(DEPTH)+1.
// STRUCTURE
//  Shared header: ENTRY default, MIPS opcode/funct constants, BID_W default, is_branch
//   predecode macro/function (reused by IDU).
//  Sub-module ifu_queue: DEPTH x (32+32+1+BID_W) circular buffer, push/pop/clear,
//   head/tail wrap at DEPTH, count output. Everything else in ifu_fetch_queue.
// TESTING
//  1 Reset, req_ready=1, resp 1 cycle later: req_addr 1fc00000,1fc00004,...; out_pc
//    bfc00000,+4 in order; out_ds=0.
//  2 out_ready=0: exactly DEPTH=4 requests issued, then req_valid=0; release -> 4 pops,
//    fetch resumes; no overflow assertion.
//  3 Enqueue BEQ (0x10000003) at bfc00008: its out_bid=1, next entry out_ds=1 out_bid=1,
//    following entry out_ds=0; bid wraps 15->0 after 16 branches.
//  4 Redirect to 80001000 with 3 in flight, resp in same cycle: 3 responses discarded
//    total, next out_pc=80001000, req_addr=00001000, out_valid=0 in R+1.
//  5 Redirect while queue full and out_ready=1: no pop counted, queue empty next cycle.
//  6 Random req_ready/resp delay/out_ready/redirects vs reference model: PC stream
//    matches model; inflight<=MAX_OUTST; count<=DEPTH always.

Source files
------------

// File: rtl/ifu_fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// ifu_fetch_queue_pkg
//   Shared fetch-front-end header: reset fetch PC, default branch-id width,
//   MIPS opcode/funct constants and the branch predecode helper.
//   The IDU reuses the same predecode.
//   Contents:
//     ENTRY_PC   reset fetch PC (kseg1 boot vector)
//     BID_W_DEF  default branch-id width
//     OP_* / FN_*  primary opcode and SPECIAL funct codes
//     is_branch  1 when an instruction is a control transfer that owns a
//                delay slot
// ---------------------------------------------------------------------------
package ifu_fetch_queue_pkg;

  localparam logic [31:0] ENTRY_PC  = 32'hbfc00000;
  localparam int          BID_W_DEF = 4;

  // Primary opcodes (instr[31:26]).
  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_REGIMM  = 6'd1;
  localparam logic [5:0] OP_J       = 6'd2;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] OP_BEQ     = 6'd4;
  localparam logic [5:0] OP_BNE     = 6'd5;
  localparam logic [5:0] OP_BLEZ    = 6'd6;
  localparam logic [5:0] OP_BGTZ    = 6'd7;
  localparam logic [5:0] OP_BEQL    = 6'd20;
  localparam logic [5:0] OP_BNEL    = 6'd21;
  localparam logic [5:0] OP_BLEZL   = 6'd22;
  localparam logic [5:0] OP_BGTZL   = 6'd23;

  // SPECIAL funct codes (instr[5:0]).
  localparam logic [5:0] FN_JR      = 6'd8;
  localparam logic [5:0] FN_JALR    = 6'd9;

  // Takes only the opcode and funct fields so callers pass exactly the
  // bits that matter.
  function automatic logic is_branch(input logic [5:0] op, input logic [5:0] funct);
    logic br;
    case (op)
      OP_SPECIAL: br = (funct == FN_JR) || (funct == FN_JALR);
      OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
      OP_BEQL, OP_BNEL, OP_BLEZL, OP_BGTZL: br = 1'b1;
      default:    br = 1'b0;
    endcase
    return br;
  endfunction

endpackage

// File: rtl/ifu_queue.sv
// ---------------------------------------------------------------------------
// ifu_queue
//   DEPTH-entry circular instruction buffer. Write is registered, and the
//   head is read combinationally. An entry pushed in cycle N is therefore
//   at the head in cycle N+1 when the queue was empty.
//   Ports:
//     clk, rst         clock, synchronous active-high reset
//     clear            flush all entries; dominates push and pop
//     push, push_data  append an entry at the tail
//     pop              drop the head entry (ignored when empty)
//     head_data        entry at the head (valid while count != 0)
//     count            number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module ifu_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 69
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            push_en, pop_en, full;

  always_comb begin
    full    = (count_q == CNTW'(DEPTH));
    pop_en  = pop && !clear && (count_q != '0);
    push_en = push && !clear;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push_en) tail_d = tail_q + PW'(1);
      if (pop_en)  head_d = head_q + PW'(1);
      count_d = count_q + CNTW'(push_en) - CNTW'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset. Stale contents are never visible because
  // count gates validity.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[tail_q] <= push_data;
  end

  // The fetch credit scheme must never push into a full queue unless the
  // same cycle also pops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push_en && full && !pop_en));
    end
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;

endmodule

// File: rtl/ifu_fetch_queue.sv
// ---------------------------------------------------------------------------
// ifu_fetch_queue
//   Instruction-fetch front end. It issues up to MAX_OUTST pipelined fetch
//   requests. In-order responses are buffered in a DEPTH-entry queue and
//   presented to the decoder with PC, delay-slot flag and branch id.
//   A redirect flushes the queue and discards responses that are still in
//   flight. Fetching resumes the cycle after the redirect.
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     redir_valid, redir_pc       redirect from writeback (always accepted)
//     req_valid/ready, req_addr   fetch request (physical address)
//     resp_valid, resp_instr      in-order fetch response (always accepted)
//     out_valid/ready             instruction handshake to decode
//     out_instr, out_pc           instruction word and its virtual PC
//     out_ds, out_bid             delay-slot flag, owning branch id
// ---------------------------------------------------------------------------
module ifu_fetch_queue
  import ifu_fetch_queue_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 4,
  parameter logic [31:0] ENTRY     = ENTRY_PC,
  parameter int          BID_W     = BID_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redir_valid,
  input  logic [31:0]      redir_pc,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [31:0]      req_addr,
  input  logic             resp_valid,
  input  logic [31:0]      resp_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic             out_ds,
  output logic [BID_W-1:0] out_bid
);

  localparam int CW = $clog2(MAX_OUTST) + 1;
  localparam int QW = $clog2(DEPTH) + 1;
  localparam int SW = ((CW > QW) ? CW : QW) + 1;
  localparam int EW = 32 + 32 + 1 + BID_W;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      enq_pc_q, enq_pc_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    drop_cnt_q, drop_cnt_d;
  logic             prev_br_q, prev_br_d;
  logic [BID_W-1:0] bid_q, bid_d;

  logic [QW-1:0]    q_count;
  logic [EW-1:0]    q_head;
  logic [EW-1:0]    q_push_data;
  logic             q_push, q_pop;
  logic [SW-1:0]    occupancy;
  logic             req_fire;
  logic             resp_keep;
  logic             resp_br;
  logic [BID_W-1:0] ent_bid;
  logic             unused_fetch_hi;

  // ---------------------------------------------------------------------
  // Request issue. Queue slots are reserved for every outstanding
  // request, so a response can always be enqueued without back-pressure.
  // ---------------------------------------------------------------------
  always_comb begin
    occupancy = SW'(inflight_q) + SW'(q_count);
    req_valid = !rst && !redir_valid
                && (occupancy < SW'(DEPTH))
                && (inflight_q < CW'(MAX_OUTST));
    req_fire  = req_valid && req_ready;
    // Fold kseg0/kseg1 onto physical memory.
    req_addr  = {3'b000, fetch_pc_q[28:0]};
  end

  assign unused_fetch_hi = ^fetch_pc_q[31:29];

  // ---------------------------------------------------------------------
  // Response handling and predecode.
  // The entry following a branch is its delay slot. A branch takes a
  // fresh id, and its delay slot inherits that id.
  // ---------------------------------------------------------------------
  always_comb begin
    resp_br     = is_branch(resp_instr[31:26], resp_instr[5:0]);
    ent_bid     = resp_br ? (bid_q + BID_W'(1)) : bid_q;
    resp_keep   = resp_valid && !redir_valid && (drop_cnt_q == '0);
    q_push      = resp_keep;
    q_push_data = {resp_instr, enq_pc_q, prev_br_q, ent_bid};
    // On a redirect the queue clear takes priority over the pop.
    q_pop       = out_valid && out_ready;
  end

  // ---------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    enq_pc_d   = enq_pc_q;
    drop_cnt_d = drop_cnt_q;
    prev_br_d  = prev_br_q;
    bid_d      = bid_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(resp_valid);

    if (redir_valid) begin
      fetch_pc_d = redir_pc;
      enq_pc_d   = redir_pc;
      prev_br_d  = 1'b0;
      // Everything still outstanding after this cycle belongs to the
      // squashed path. A response arriving now is already discarded.
      drop_cnt_d = inflight_q - CW'(resp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (resp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
      if (resp_keep) begin
        enq_pc_d  = enq_pc_q + 32'd4;
        prev_br_d = resp_br;
        bid_d     = ent_bid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= ENTRY;
      enq_pc_q   <= ENTRY;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      prev_br_q  <= 1'b0;
      bid_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      enq_pc_q   <= enq_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      prev_br_q  <= prev_br_d;
      bid_q      <= bid_d;
    end
  end

  // Protocol sanity: responses only for issued requests, and the drop
  // counter stays within the outstanding window.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(resp_valid && (inflight_q == '0)));
      assert (inflight_q <= CW'(MAX_OUTST));
      assert (drop_cnt_q <= inflight_q);
    end
  end

  // ---------------------------------------------------------------------
  // Instruction queue
  // ---------------------------------------------------------------------
  ifu_queue #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (redir_valid),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .head_data (q_head),
    .count     (q_count)
  );

  always_comb begin
    out_valid = !rst && (q_count != '0);
    out_instr = q_head[EW-1 -: 32];
    out_pc    = q_head[EW-33 -: 32];
    out_ds    = q_head[BID_W];
    out_bid   = q_head[BID_W-1:0];
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch_queue
//   The bench acts as the fetch port and the decoder. A transaction-level
//   model tracks the expected program stream:
//     - requests are tagged with a path epoch;
//     - responses of a squashed epoch, or that arrive in a redirect cycle,
//       never reach decode;
//     - the delay-slot flag and branch id are derived from the instruction
//       order.
//   Every cycle the outputs are compared against the model. Directed
//   phases add literal expectations.
// ---------------------------------------------------------------------------
module tb_ifu_fetch_queue;

  localparam int          DEPTH     = 4;
  localparam int          MAX_OUTST = 4;
  localparam int          BID_W     = 4;
  localparam logic [31:0] ENTRY     = 32'hbfc00000;

  logic             clk = 1'b0;
  logic             rst;
  logic             redir_valid;
  logic [31:0]      redir_pc;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_addr;
  logic             resp_valid;
  logic [31:0]      resp_instr;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [31:0]      out_pc;
  logic             out_ds;
  logic [BID_W-1:0] out_bid;

  ifu_fetch_queue #(
    .DEPTH     (DEPTH),
    .MAX_OUTST (MAX_OUTST),
    .ENTRY     (ENTRY),
    .BID_W     (BID_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .resp_valid  (resp_valid),
    .resp_instr  (resp_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_ds      (out_ds),
    .out_bid     (out_bid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          ds;
    logic [3:0]  bid;
  } ent_t;

  req_t        pend[$];      // requests accepted by the fetch port, oldest first
  ent_t        mq[$];        // instructions the decoder must see next
  ent_t        out_log[$];   // instructions the decoder actually accepted
  logic [31:0] req_log[$];   // addresses of accepted requests

  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  int          rdy_pct, resp_pct, ordy_pct, dly_max;
  logic [31:0] m_fetch_pc;
  int          m_epoch  = 0;
  bit          m_prev_br;
  logic [3:0]  m_bid;
  int          n_dropped = 0;
  bit          last_req_valid, last_req_fire, last_out_valid;
  logic [31:0] last_req_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, want);
    end
  endtask

  // Program memory, indexed by virtual PC.
  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    logic [31:0] h;
    if (pc == 32'hbfc00008) return 32'h10000003;          // BEQ
    if (pc[31:12] == 20'h80002) return 32'h10000003;      // all-branch region
    if (pc[31:28] == 4'h9 || pc[31:28] == 4'ha) begin
      h = pc * 32'h9e3779b1;
      case (h[31:29])
        3'd0: return 32'h10000003;                        // BEQ
        3'd1: return 32'h03e00008;                        // JR
        3'd2: return 32'h0040f809;                        // JALR
        3'd3: return 32'h08000100;                        // J
        3'd4: return 32'h54000002;                        // BNEL
        3'd5: return 32'h00851021;                        // ADDU (SPECIAL, not a jump)
        3'd6: return {16'h6000, pc[15:0]};                // opcode 24, not a branch
        default: return {16'h2400, pc[15:0]};             // ADDIU
      endcase
    end
    return {16'h2400, pc[15:0]};
  endfunction

  // Control transfers: REGIMM, J, JAL, BEQ..BGTZ, the branch-likely
  // group, and SPECIAL with funct JR/JALR.
  function automatic bit model_is_branch(input logic [31:0] w);
    int op;
    op = int'(w[31:26]);
    if (op == 0) return (w[5:0] == 6'd8) || (w[5:0] == 6'd9);
    return (op >= 1 && op <= 7) || (op >= 20 && op <= 23);
  endfunction

  function automatic ent_t log_at(input int i);
    ent_t e;
    e.pc = 32'hdeaddead; e.instr = 32'hdeaddead; e.ds = 1'b1; e.bid = 4'ha;
    if (i < out_log.size()) e = out_log[i];
    return e;
  endfunction

  function automatic logic [31:0] req_at(input int i);
    if (i < req_log.size()) return req_log[i];
    return 32'hdeaddead;
  endfunction

  task automatic do_reset();
    rst = 1'b1; redir_valid = 1'b1; redir_pc = 32'h80005000;
    req_ready = 1'b1; resp_valid = 1'b0; resp_instr = 32'h0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_req_valid", 32'(req_valid), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0; redir_valid = 1'b0;
    pend.delete(); mq.delete();
    m_fetch_pc = ENTRY; m_prev_br = 1'b0; m_bid = 4'd0; m_epoch++;
    $display("reset done, fetch from %h", ENTRY);
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic do_cycle(input bit redir, input logic [31:0] tgt);
    bit   rv, exp_rv, exp_ov, acc, br;
    req_t r;
    ent_t e;
    redir_valid = redir;
    redir_pc    = tgt;
    req_ready   = ($urandom_range(99) < rdy_pct);
    out_ready   = ($urandom_range(99) < ordy_pct);
    rv = 1'b0;
    if (pend.size() != 0) begin
      if (pend[0].due <= cyc && $urandom_range(99) < resp_pct) rv = 1'b1;
    end
    resp_valid = rv;
    resp_instr = rv ? mem_word(pend[0].pc) : 32'h0;

    @(negedge clk);
    exp_rv = !redir && (pend.size() + mq.size() < DEPTH) && (pend.size() < MAX_OUTST);
    check("req_valid", 32'(req_valid), 32'(exp_rv));
    if (req_valid) check("req_addr", req_addr, {3'b000, m_fetch_pc[28:0]});
    exp_ov = (mq.size() != 0);
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      check("out_pc", out_pc, mq[0].pc);
      check("out_instr", out_instr, mq[0].instr);
      check("out_ds", 32'(out_ds), 32'(mq[0].ds));
      check("out_bid", 32'(out_bid), 32'(mq[0].bid));
    end
    check("occupancy_bound", 32'(pend.size() <= MAX_OUTST && pend.size() + mq.size() <= DEPTH), 32'd1);

    last_req_valid = req_valid;
    last_req_fire  = req_valid && req_ready;
    last_req_addr  = req_addr;
    last_out_valid = out_valid;

    acc = exp_ov && out_ready && !redir;
    if (acc) begin
      e.pc = out_pc; e.instr = out_instr; e.ds = out_ds; e.bid = out_bid;
      out_log.push_back(e);
      $display("cyc %0d: decode pc=%h instr=%h ds=%0d bid=%0d", cyc, out_pc, out_instr, out_ds, out_bid);
      void'(mq.pop_front());
    end
    if (rv) begin
      r = pend.pop_front();
      if (!redir && r.epoch == m_epoch) begin
        e.pc = r.pc;
        e.instr = mem_word(r.pc);
        br = model_is_branch(e.instr);
        e.ds = m_prev_br;
        if (br) m_bid = m_bid + 4'd1;
        e.bid = m_bid;
        m_prev_br = br;
        mq.push_back(e);
      end else begin
        n_dropped++;
      end
    end
    if (redir) begin
      mq.delete();
      m_epoch++;
      m_fetch_pc = tgt;
      m_prev_br = 1'b0;
      $display("cyc %0d: redirect to %h", cyc, tgt);
    end
    if (req_valid && req_ready) begin
      r.pc = m_fetch_pc; r.epoch = m_epoch; r.due = cyc + 1 + int'($urandom_range(dly_max));
      pend.push_back(r);
      req_log.push_back(req_addr);
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 32'h0);
  endtask

  initial begin
    int base;
    ent_t e;
    logic [31:0] tgt;

    // --- 1/3: straight-line fetch with a BEQ at bfc00008 ---
    rdy_pct = 100; resp_pct = 100; ordy_pct = 100; dly_max = 0;
    do_reset();
    req_log.delete(); out_log.delete();
    run(14);
    check("t1_req0", req_at(0), 32'h1fc00000);
    check("t1_req1", req_at(1), 32'h1fc00004);
    check("t1_req2", req_at(2), 32'h1fc00008);
    e = log_at(0); check("t1_out0_pc", e.pc, 32'hbfc00000); check("t1_out0_ds", 32'(e.ds), 32'd0);
    e = log_at(1); check("t1_out1_pc", e.pc, 32'hbfc00004);
    e = log_at(2); check("t3_beq_instr", e.instr, 32'h10000003); check("t3_beq_bid", 32'(e.bid), 32'd1);
                   check("t3_beq_ds", 32'(e.ds), 32'd0);
    e = log_at(3); check("t3_slot_ds", 32'(e.ds), 32'd1); check("t3_slot_bid", 32'(e.bid), 32'd1);
    e = log_at(4); check("t3_after_ds", 32'(e.ds), 32'd0); check("t3_after_bid", 32'(e.bid), 32'd1);

    // --- 2: decoder stalled, credits cap issue at DEPTH ---
    do_reset();
    ordy_pct = 0;
    req_log.delete(); out_log.delete();
    run(15);
    check("t2_req_count", 32'(req_log.size()), 32'd4);
    check("t2_req_stalled", 32'(last_req_valid), 32'd0);
    ordy_pct = 100;
    run(20);
    e = log_at(0); check("t2_pop0_pc", e.pc, 32'hbfc00000);
    e = log_at(3); check("t2_pop3_pc", e.pc, 32'hbfc0000c);
    check("t2_resumed", 32'(req_log.size() > 4), 32'd1);

    // --- 3: branch id wraps after 16 branches ---
    do_reset();
    out_log.delete();
    do_cycle(1'b1, 32'h80002000);
    run(30);
    e = log_at(0);  check("t3w_pc0", e.pc, 32'h80002000); check("t3w_bid0", 32'(e.bid), 32'd1);
                    check("t3w_ds0", 32'(e.ds), 32'd0);
    e = log_at(1);  check("t3w_ds1", 32'(e.ds), 32'd1);   check("t3w_bid1", 32'(e.bid), 32'd2);
    e = log_at(14); check("t3w_bid14", 32'(e.bid), 32'd15);
    e = log_at(15); check("t3w_bid15", 32'(e.bid), 32'd0);
    e = log_at(16); check("t3w_bid16", 32'(e.bid), 32'd1);

    // --- 4: redirect with 3 in flight and a response in the same cycle ---
    do_reset();
    resp_pct = 0;
    run(3);
    check("t4_pending", 32'(pend.size()), 32'd3);
    resp_pct = 100;
    base = n_dropped;
    out_log.delete();
    do_cycle(1'b1, 32'h80001000);
    check("t4_no_req_in_r", 32'(last_req_valid), 32'd0);
    do_cycle(1'b0, 32'h0);
    check("t4_out_valid_r1", 32'(last_out_valid), 32'd0);
    check("t4_req_fire_r1", 32'(last_req_fire), 32'd1);
    check("t4_req_addr_r1", last_req_addr, 32'h00001000);
    run(10);
    check("t4_dropped", 32'(n_dropped - base), 32'd3);
    e = log_at(0); check("t4_first_pc", e.pc, 32'h80001000);

    // --- 5: redirect while the queue is full and decode is ready ---
    do_reset();
    ordy_pct = 0;
    run(12);
    ordy_pct = 100;
    out_log.delete();
    do_cycle(1'b1, 32'h80001100);
    check("t5_full_valid_r", 32'(last_out_valid), 32'd1);
    check("t5_no_req_r", 32'(last_req_valid), 32'd0);
    do_cycle(1'b0, 32'h0);
    check("t5_empty_r1", 32'(last_out_valid), 32'd0);
    run(10);
    e = log_at(0); check("t5_first_pc", e.pc, 32'h80001100);

    // --- 6: random handshakes, delays and redirects ---
    do_reset();
    rdy_pct = 70; resp_pct = 70; ordy_pct = 60; dly_max = 3;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(99) < 3) begin
        tgt = {($urandom_range(1) != 0) ? 4'h9 : 4'ha, 26'($urandom), 2'b00};
        do_cycle(1'b1, tgt);
      end else begin
        do_cycle(1'b0, 32'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
